// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the single-bus control sequencer.
// Opcodes, control-step states, op classes and bus source indices.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_ROR  = 5'd9;
    localparam logic [4:0] OP_ROL  = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam int BS_HI     = 16;
    localparam int BS_LO     = 17;
    localparam int BS_ZHI    = 18;
    localparam int BS_ZLO    = 19;
    localparam int BS_PC     = 20;
    localparam int BS_MDR    = 21;
    localparam int BS_INPORT = 22;
    localparam int BS_C      = 23;

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        C_NOP,
        C_ALU,
        C_IMM,
        C_LDI,
        C_LD,
        C_ST,
        C_MD,
        C_MFHI,
        C_MFLO,
        C_JR,
        C_IN,
        C_OUT,
        C_HALT
    } op_class_t;

    // Undefined opcodes fall into C_NOP so they fetch and return.
    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_class = C_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:       op_class = C_IMM;
            OP_LDI:                         op_class = C_LDI;
            OP_LD:                          op_class = C_LD;
            OP_ST:                          op_class = C_ST;
            OP_MUL, OP_DIV:                 op_class = C_MD;
            OP_MFHI:                        op_class = C_MFHI;
            OP_MFLO:                        op_class = C_MFLO;
            OP_JR:                          op_class = C_JR;
            OP_IN:                          op_class = C_IN;
            OP_OUT:                         op_class = C_OUT;
            OP_HALT:                        op_class = C_HALT;
            default:                        op_class = C_NOP;
        endcase
    endfunction

endpackage

// File: rtl/bus_control_sequencer_select_encode.sv
// Gra/Grb/Grc field select and 4-to-16 decode.
// Produces R0..R15 load strobes and R0..R15 bus-out strobes.
module select_encode
    import cpu_ctrl_pkg::*;
#(
    parameter int RFW = 4
) (
    input  logic [31:0] ir,
    input  logic        gra,
    input  logic        grb,
    input  logic        grc,
    input  logic        rin,
    input  logic        rout,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out
);

    logic [RFW-1:0] sel;
    logic           hit;
    logic           unused_ir;

    assign unused_ir = ^{ir[31:27], ir[14:0]};

    // Pick one register field, then decode it onto in/out strobes.
    always_comb begin
        sel     = '0;
        hit     = 1'b0;
        reg_in  = '0;
        reg_out = '0;
        unique case (1'b1)
            gra: begin
                sel = ir[26 -: RFW];
                hit = 1'b1;
            end
            grb: begin
                sel = ir[22 -: RFW];
                hit = 1'b1;
            end
            grc: begin
                sel = ir[18 -: RFW];
                hit = 1'b1;
            end
            default: begin
                sel = '0;
                hit = 1'b0;
            end
        endcase
        if (hit && rin)
            reg_in[sel] = 1'b1;
        if (hit && rout)
            reg_out[sel] = 1'b1;
    end

endmodule

// File: rtl/bus_control_sequencer.sv
// Control-step sequencer for the single-bus datapath.
// Fetch T0..T2, execute T3..T7, decoded one-hot bus and load strobes.
module bus_control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 5,
    parameter int RFW = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [31:0]    ir,
    input  logic           mem_ready,
    output logic [23:0]    bus_src,
    output logic [15:0]    reg_in,
    output logic           hi_in,
    output logic           lo_in,
    output logic           z_in,
    output logic           y_in,
    output logic           pc_in,
    output logic           ir_in,
    output logic           mar_in,
    output logic           mdr_in,
    output logic           outport_in,
    output logic           inc_pc,
    output logic [OPW-1:0] alu_op,
    output logic           read,
    output logic           write,
    output logic           run
);

    state_t         state;
    state_t         state_nx;
    logic [OPW-1:0] op;
    op_class_t      cls;
    logic           gra;
    logic           grb;
    logic           grc;
    logic           rin;
    logic           rout;
    logic [23:0]    sp;
    logic [15:0]    r_out;

    assign op  = ir[31 -: OPW];
    assign cls = op_class(op);

    select_encode #(.RFW(RFW)) u_sel (
        .ir      (ir),
        .gra     (gra),
        .grb     (grb),
        .grc     (grc),
        .rin     (rin),
        .rout    (rout),
        .reg_in  (reg_in),
        .reg_out (r_out)
    );

    assign bus_src = sp | {8'b0, r_out};

    // Control-step register; reset aborts any instruction.
    always_ff @(posedge clock) begin
        if (reset)
            state <= T0;
        else
            state <= state_nx;
    end

    // Step sequencing, including memory wait holds.
    always_comb begin
        state_nx = state;
        case (state)
            T0: state_nx = T1;
            T1: state_nx = mem_ready ? T2 : T1;
            T2: begin
                if (cls == C_NOP)
                    state_nx = T0;
                else if (cls == C_HALT)
                    state_nx = HALT;
                else
                    state_nx = T3;
            end
            T3: begin
                if (cls inside {C_ALU, C_IMM, C_LDI,
                                C_LD, C_ST, C_MD})
                    state_nx = T4;
                else
                    state_nx = T0;
            end
            T4: state_nx = T5;
            T5: begin
                if (cls inside {C_LD, C_ST, C_MD})
                    state_nx = T6;
                else
                    state_nx = T0;
            end
            T6: begin
                if (cls == C_LD)
                    state_nx = mem_ready ? T7 : T6;
                else if (cls == C_ST)
                    state_nx = T7;
                else
                    state_nx = T0;
            end
            T7: begin
                if (cls == C_ST)
                    state_nx = mem_ready ? T0 : T7;
                else
                    state_nx = T0;
            end
            HALT: state_nx = HALT;
            default: state_nx = T0;
        endcase
    end

    // Per-step strobes; everything but run is forced low in reset.
    always_comb begin
        sp         = '0;
        gra        = 1'b0;
        grb        = 1'b0;
        grc        = 1'b0;
        rin        = 1'b0;
        rout       = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        z_in       = 1'b0;
        y_in       = 1'b0;
        pc_in      = 1'b0;
        ir_in      = 1'b0;
        mar_in     = 1'b0;
        mdr_in     = 1'b0;
        outport_in = 1'b0;
        inc_pc     = 1'b0;
        alu_op     = '0;
        read       = 1'b0;
        write      = 1'b0;
        run        = 1'b1;
        if (!reset) begin
            case (state)
                T0: begin
                    sp[BS_PC] = 1'b1;
                    mar_in    = 1'b1;
                    inc_pc    = 1'b1;
                    z_in      = 1'b1;
                end
                T1: begin
                    sp[BS_ZLO] = 1'b1;
                    read       = 1'b1;
                    mdr_in     = 1'b1;
                    pc_in      = mem_ready;
                end
                T2: begin
                    sp[BS_MDR] = 1'b1;
                    ir_in      = 1'b1;
                end
                T3: begin
                    case (cls)
                        C_ALU, C_IMM, C_LDI, C_LD, C_ST: begin
                            grb  = 1'b1;
                            rout = 1'b1;
                            y_in = 1'b1;
                        end
                        C_MD: begin
                            gra  = 1'b1;
                            rout = 1'b1;
                            y_in = 1'b1;
                        end
                        C_MFHI: begin
                            sp[BS_HI] = 1'b1;
                            gra       = 1'b1;
                            rin       = 1'b1;
                        end
                        C_MFLO: begin
                            sp[BS_LO] = 1'b1;
                            gra       = 1'b1;
                            rin       = 1'b1;
                        end
                        C_JR: begin
                            gra   = 1'b1;
                            rout  = 1'b1;
                            pc_in = 1'b1;
                        end
                        C_IN: begin
                            sp[BS_INPORT] = 1'b1;
                            gra           = 1'b1;
                            rin           = 1'b1;
                        end
                        C_OUT: begin
                            gra        = 1'b1;
                            rout       = 1'b1;
                            outport_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    case (cls)
                        C_ALU: begin
                            grc    = 1'b1;
                            rout   = 1'b1;
                            alu_op = op;
                            z_in   = 1'b1;
                        end
                        C_IMM: begin
                            sp[BS_C] = 1'b1;
                            alu_op   = op;
                            z_in     = 1'b1;
                        end
                        C_LDI, C_LD, C_ST: begin
                            sp[BS_C] = 1'b1;
                            alu_op   = OP_ADD;
                            z_in     = 1'b1;
                        end
                        C_MD: begin
                            grb    = 1'b1;
                            rout   = 1'b1;
                            alu_op = op;
                            z_in   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (cls)
                        C_ALU, C_IMM, C_LDI: begin
                            sp[BS_ZLO] = 1'b1;
                            gra        = 1'b1;
                            rin        = 1'b1;
                        end
                        C_LD, C_ST: begin
                            sp[BS_ZLO] = 1'b1;
                            mar_in     = 1'b1;
                        end
                        C_MD: begin
                            sp[BS_ZLO] = 1'b1;
                            lo_in      = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    case (cls)
                        C_LD: begin
                            read   = 1'b1;
                            mdr_in = 1'b1;
                        end
                        C_ST: begin
                            gra    = 1'b1;
                            rout   = 1'b1;
                            mdr_in = 1'b1;
                        end
                        C_MD: begin
                            sp[BS_ZHI] = 1'b1;
                            hi_in      = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T7: begin
                    case (cls)
                        C_LD: begin
                            sp[BS_MDR] = 1'b1;
                            gra        = 1'b1;
                            rin        = 1'b1;
                        end
                        C_ST: write = 1'b1;
                        default: ;
                    endcase
                end
                HALT: run = 1'b0;
                default: ;
            endcase
        end
    end

endmodule
